hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_if.sv | 32 +++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// Issue/operand bus between decode and the hazard scoreboard.
// The master is the decode stage; the slave is the scoreboard.
interface hazard_scoreboard_if #(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned RD_PORTS  = 2,
   parameter int unsigned LAT_W     = 2,
   parameter int unsigned CNT_W     = 6
);
   logic                         issue_valid;
   logic                         issue_we;
   logic [ADDR_W-1:0]            issue_dest;
   logic [LAT_W-1:0]             issue_lat;
   logic [RD_PORTS-1:0]          src_valid;
   logic [RD_PORTS*ADDR_W-1:0]   src_addr;
   logic                         flush;
   logic                         stall;
   logic                         issue_accept;
   logic [RD_PORTS-1:0]          fwd_hit;
   logic [REG_COUNT-1:0]         busy_vec;
   logic [CNT_W-1:0]             pending_count;

   modport master (
      output issue_valid, issue_we, issue_dest, issue_lat, src_valid, src_addr, flush,
      input  stall, issue_accept, fwd_hit, busy_vec, pending_count
   );

   modport slave (
      input  issue_valid, issue_we, issue_dest, issue_lat, src_valid, src_addr, flush,
      output stall, issue_accept, fwd_hit, busy_vec, pending_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register write-back countdowns that
// produce RAW/WAW stalls, issue acceptance and bypass hints.
// Optional feature: define HAZARD_SCOREBOARD_FWD_EN to let an operand whose
// producer writes back next cycle proceed through the bypass path.
module hazard_scoreboard #(
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned RD_PORTS  = 2,
   parameter int unsigned LAT_W     = 2,
   parameter int unsigned CNT_W     = 6
) (
   input logic                clk,
   input logic                rst,
   hazard_scoreboard_if.slave bus
);
   // Counters cover the full address space; entries 0 and >= REG_COUNT stay zero.
   localparam int unsigned NREGS = 1 << ADDR_W;

   logic [LAT_W-1:0]     r_cnt     [NREGS];
   logic [LAT_W-1:0]     w_cnt_nxt [NREGS];
   logic [LAT_W-1:0]     w_src_cnt [RD_PORTS];
   logic [REG_COUNT-1:0] r_busy;
   logic [REG_COUNT-1:0] w_busy_nxt;
   logic [CNT_W-1:0]     r_pend;
   logic [CNT_W-1:0]     w_pend_nxt;
   logic [LAT_W-1:0]     w_eff_lat;
   logic [LAT_W-1:0]     w_dest_cnt;
   logic [RD_PORTS-1:0]  w_ready;
   logic [RD_PORTS-1:0]  w_fwd;
   logic                 w_raw;
   logic                 w_waw;
   logic                 w_stall;
   logic                 w_accept;
   logic                 w_load;

   // A latency of zero behaves as one cycle.
   assign w_eff_lat  = (bus.issue_lat == '0) ? LAT_W'(1) : bus.issue_lat;
   assign w_dest_cnt = r_cnt[bus.issue_dest];

   // Per-port readiness; a counter of one may be bypassed when forwarding exists.
   always_comb begin
      w_ready = '1;
      w_fwd   = '0;
      for (int unsigned k = 0; k < RD_PORTS; k++) begin
         w_src_cnt[k] = r_cnt[bus.src_addr[k*ADDR_W +: ADDR_W]];
         if (bus.src_valid[k] && (w_src_cnt[k] != '0)) begin
`ifdef HAZARD_SCOREBOARD_FWD_EN
            if (w_src_cnt[k] == LAT_W'(1)) w_fwd[k]   = 1'b1;
            else                           w_ready[k] = 1'b0;
`else
            w_ready[k] = 1'b0;
`endif
         end
      end
   end

   // Stall and acceptance decisions.
   always_comb begin
      w_raw    = bus.issue_valid & ~(&w_ready);
      w_waw    = bus.issue_valid & bus.issue_we & (bus.issue_dest != '0) &
                 (w_dest_cnt >= w_eff_lat);
      w_stall  = w_raw | w_waw;
      w_accept = bus.issue_valid & ~w_stall & ~bus.flush & ~rst;
      w_load   = w_accept & bus.issue_we;
   end

   // Next counter values: flush beats load, load beats decrement.
   always_comb begin
      w_busy_nxt = '0;
      w_pend_nxt = '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         w_cnt_nxt[r] = '0;
         if ((r != 0) && (r < REG_COUNT) && !bus.flush) begin
            if (w_load && (bus.issue_dest == ADDR_W'(r))) w_cnt_nxt[r] = w_eff_lat;
            else if (r_cnt[r] != '0)                     w_cnt_nxt[r] = r_cnt[r] - LAT_W'(1);
         end
      end
      for (int unsigned r = 0; r < REG_COUNT; r++) begin
         w_busy_nxt[r] = (w_cnt_nxt[r] != '0);
         w_pend_nxt    = w_pend_nxt + CNT_W'(w_busy_nxt[r]);
      end
   end

   // Counter, busy vector and pending count state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= '0;
         r_busy <= '0;
         r_pend <= '0;
      end else begin
         for (int unsigned r = 0; r < NREGS; r++) r_cnt[r] <= w_cnt_nxt[r];
         r_busy <= w_busy_nxt;
         r_pend <= w_pend_nxt;
      end
   end

   assign bus.stall         = w_stall;
   assign bus.issue_accept  = w_accept;
   assign bus.fwd_hit       = w_fwd;
   assign bus.busy_vec      = r_busy;
   assign bus.pending_count = r_pend;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed testbench for hazard_scoreboard; expectations follow the
// forwarding configuration selected by HAZARD_SCOREBOARD_FWD_EN.
module tb_hazard_scoreboard;
   localparam int unsigned REG_COUNT = 32;
   localparam int unsigned ADDR_W    = 5;
   localparam int unsigned RD_PORTS  = 2;
   localparam int unsigned LAT_W     = 2;
   localparam int unsigned CNT_W     = 6;
`ifdef HAZARD_SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   hazard_scoreboard_if #(
      .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS),
      .LAT_W(LAT_W), .CNT_W(CNT_W)
   ) bus ();

   hazard_scoreboard #(
      .REG_COUNT(REG_COUNT), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS),
      .LAT_W(LAT_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.issue_we    = 1'b0;
      bus.issue_dest  = '0;
      bus.issue_lat   = '0;
      bus.src_valid   = '0;
      bus.src_addr    = '0;
      bus.flush       = 1'b0;
   endtask

   task automatic drive_issue(input logic we, input logic [ADDR_W-1:0] dest,
                              input logic [LAT_W-1:0] lat);
      bus.issue_valid = 1'b1;
      bus.issue_we    = we;
      bus.issue_dest  = dest;
      bus.issue_lat   = lat;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      drive_issue(1'b1, 5'd5, 2'd2);
      bus.src_valid = 2'b11;
      bus.src_addr  = {5'd5, 5'd5};
      step();
      step();
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", bus.pending_count); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
      checks++; if (bus.issue_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got %b exp 0", bus.issue_accept); end
      checks++; if (bus.fwd_hit !== 2'b00) begin errors++; $display("FAIL reset_fwd got %b exp 00", bus.fwd_hit); end
      idle();
      rst = 1'b0;
      step();
   endtask

   task automatic test_raw();
      drive_issue(1'b1, 5'd5, 2'd2);
      #1;
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL raw_issue_accept got %b exp 1", bus.issue_accept); end
      step();
      bus.issue_we  = 1'b0;
      bus.src_valid = 2'b01;
      bus.src_addr  = 10'd5;
      #1;
      checks++; if (bus.busy_vec !== 32'h20) begin errors++; $display("FAIL raw_busy got %h exp 20", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd1) begin errors++; $display("FAIL raw_pend got %0d exp 1", bus.pending_count); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall_c2 got %b exp 1", bus.stall); end
      step();
      #1;
      checks++; if (bus.stall !== !FWD) begin errors++; $display("FAIL raw_stall_c1 got %b exp %b", bus.stall, !FWD); end
      checks++; if (bus.fwd_hit !== (FWD ? 2'b01 : 2'b00)) begin errors++; $display("FAIL raw_fwd_c1 got %b exp %b", bus.fwd_hit, FWD ? 2'b01 : 2'b00); end
      checks++; if (bus.issue_accept !== FWD) begin errors++; $display("FAIL raw_accept_c1 got %b exp %b", bus.issue_accept, FWD); end
      step();
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL raw_stall_c0 got %b exp 0", bus.stall); end
      checks++; if (bus.fwd_hit !== 2'b00) begin errors++; $display("FAIL raw_fwd_c0 got %b exp 00", bus.fwd_hit); end
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL raw_busy_drained got %h exp 0", bus.busy_vec); end
      idle();
      step();
   endtask

   task automatic test_reg0();
      drive_issue(1'b1, 5'd0, 2'd3);
      #1;
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL reg0_accept got %b exp 1", bus.issue_accept); end
      step();
      bus.issue_we  = 1'b0;
      bus.src_valid = 2'b01;
      bus.src_addr  = 10'd0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reg0_stall got %b exp 0", bus.stall); end
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL reg0_busy got %h exp 0", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd0) begin errors++; $display("FAIL reg0_pend got %0d exp 0", bus.pending_count); end
      idle();
      step();
   endtask

   task automatic test_waw();
      int n;
      drive_issue(1'b1, 5'd7, 2'd3);
      step();
      drive_issue(1'b1, 5'd7, 2'd1);
      n = 0;
      #1;
      while (bus.stall === 1'b1 && n < 8) begin
         n++;
         @(posedge clk);
         #2;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL waw_stall_cycles got %0d exp 3", n); end
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL waw_accept got %b exp 1", bus.issue_accept); end
      step();
      idle();
      checks++; if (bus.busy_vec !== 32'h80) begin errors++; $display("FAIL waw_busy_after got %h exp 80", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd1) begin errors++; $display("FAIL waw_pend_after got %0d exp 1", bus.pending_count); end
      step();
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL waw_cnt1_drain got %h exp 0", bus.busy_vec); end
      // Boundary: a pending count equal to the new latency stalls, a smaller one does not.
      drive_issue(1'b1, 5'd7, 2'd3);
      step();
      idle();
      step();
      drive_issue(1'b1, 5'd7, 2'd2);
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL waw_equal_stall got %b exp 1", bus.stall); end
      bus.issue_lat = 2'd3;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL waw_longer_stall got %b exp 0", bus.stall); end
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL waw_longer_accept got %b exp 1", bus.issue_accept); end
      step();
      idle();
      checks++; if (bus.busy_vec !== 32'h80) begin errors++; $display("FAIL waw_reload_busy got %h exp 80", bus.busy_vec); end
      repeat (4) step();
   endtask

   task automatic test_flush();
      drive_issue(1'b1, 5'd3, 2'd3);
      step();
      checks++; if (bus.pending_count !== 6'd1) begin errors++; $display("FAIL flush_pend1 got %0d exp 1", bus.pending_count); end
      drive_issue(1'b1, 5'd4, 2'd3);
      step();
      checks++; if (bus.pending_count !== 6'd2) begin errors++; $display("FAIL flush_pend2 got %0d exp 2", bus.pending_count); end
      drive_issue(1'b1, 5'd9, 2'd3);
      step();
      checks++; if (bus.pending_count !== 6'd3) begin errors++; $display("FAIL flush_pend3 got %0d exp 3", bus.pending_count); end
      checks++; if (bus.busy_vec !== 32'h218) begin errors++; $display("FAIL flush_busy3 got %h exp 218", bus.busy_vec); end
      drive_issue(1'b1, 5'd10, 2'd1);
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.issue_accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %b exp 0", bus.issue_accept); end
      step();
      idle();
      checks++; if (bus.pending_count !== 6'd0) begin errors++; $display("FAIL flush_pend0 got %0d exp 0", bus.pending_count); end
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL flush_busy0 got %h exp 0", bus.busy_vec); end
      step();
   endtask

   task automatic test_rst_mid();
      drive_issue(1'b1, 5'd12, 2'd2);
      step();
      bus.issue_we  = 1'b0;
      bus.src_valid = 2'b01;
      bus.src_addr  = 10'd12;
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall got %b exp 1", bus.stall); end
      rst = 1'b1;
      #1;
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL rstmid_busy got %h exp 0", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd0) begin errors++; $display("FAIL rstmid_pend got %0d exp 0", bus.pending_count); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", bus.stall); end
      checks++; if (bus.issue_accept !== 1'b0) begin errors++; $display("FAIL rstmid_accept got %b exp 0", bus.issue_accept); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_post_stall got %b exp 0", bus.stall); end
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL rstmid_post_accept got %b exp 1", bus.issue_accept); end
      step();
      idle();
      step();
   endtask

   task automatic test_dual_port();
      int n;
      drive_issue(1'b1, 5'd6, 2'd2);
      step();
      drive_issue(1'b1, 5'd10, 2'd0);
      bus.src_valid = 2'b11;
      bus.src_addr  = {5'd6, 5'd6};
      #1;
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL dual_stall got %b exp 1", bus.stall); end
      checks++; if (bus.fwd_hit !== 2'b00) begin errors++; $display("FAIL dual_fwd_early got %b exp 00", bus.fwd_hit); end
      n = 0;
      while (bus.stall === 1'b1 && n < 8) begin
         n++;
         @(posedge clk);
         #2;
      end
      checks++; if (n !== (FWD ? 1 : 2)) begin errors++; $display("FAIL dual_stall_cycles got %0d exp %0d", n, FWD ? 1 : 2); end
      checks++; if (bus.fwd_hit !== (FWD ? 2'b11 : 2'b00)) begin errors++; $display("FAIL dual_fwd got %b exp %b", bus.fwd_hit, FWD ? 2'b11 : 2'b00); end
      checks++; if (bus.issue_accept !== 1'b1) begin errors++; $display("FAIL dual_accept got %b exp 1", bus.issue_accept); end
      step();
      idle();
      checks++; if (bus.busy_vec !== 32'h400) begin errors++; $display("FAIL dual_busy got %h exp 400", bus.busy_vec); end
      checks++; if (bus.pending_count !== 6'd1) begin errors++; $display("FAIL dual_pend got %0d exp 1", bus.pending_count); end
      step();
      checks++; if (bus.busy_vec !== 32'h0) begin errors++; $display("FAIL dual_lat0_drain got %h exp 0", bus.busy_vec); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_reg0();
      test_waw();
      test_flush();
      test_rst_mid();
      test_dual_port();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
